// File: rtl/divider_pkg.sv
// Shared types for the restoring divider: FSM state encoding.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_substractor_n_bits.sv
// Ripple-borrow unsigned subtractor: o_diff = i_a - i_b - i_bin, o_bout = final borrow.
module full_substractor_n_bits #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic [W-1:0] o_diff,
  output logic         o_bout
);

  logic [W:0] w_borrow;

  assign w_borrow[0] = i_bin;

  for (genvar g = 0; g < W; g++) begin : g_bit
    assign o_diff[g]       = i_a[g] ^ i_b[g] ^ w_borrow[g];
    assign w_borrow[g + 1] = (~i_a[g] & i_b[g]) | (~(i_a[g] ^ i_b[g]) & w_borrow[g]);
  end

  assign o_bout = w_borrow[W];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, N clocks per division.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_dvs;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  r_remainder;
  logic          r_dbz;

  logic [N:0]    w_shift_rem;
  logic [N-1:0]  w_shift_quo;
  logic [N:0]    w_trial;
  logic          w_borrow;
  logic          w_neg;
  logic [N-1:0]  w_next_rem;
  logic [N-1:0]  w_next_quo;

  // The shifted remainder keeps its carry-out bit so divisors above 2^(N-1) still divide correctly.
  assign w_shift_rem = {r_rem, r_quo[N-1]};
  assign w_shift_quo = {r_quo[N-2:0], 1'b0};

  full_substractor_n_bits #(
    .W(N + 1)
  ) u_trial_sub (
    .i_a   (w_shift_rem),
    .i_b   ({1'b0, r_dvs}),
    .i_bin (1'b0),
    .o_diff(w_trial),
    .o_bout(w_borrow)
  );

  // A non-negative trial is always below the divisor, so its top bit is zero unless it borrowed.
  assign w_neg      = w_borrow | w_trial[N];
  assign w_next_rem = w_neg ? w_shift_rem[N-1:0] : w_trial[N-1:0];
  assign w_next_quo = {w_shift_quo[N-1:1], ~w_neg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              r_state     <= DONE;
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= CALC;
              r_rem   <= '0;
              r_quo   <= dividend;
              r_dvs   <= divisor;
              r_cnt   <= CW'(N);
              r_dbz   <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_rem <= w_next_rem;
          r_quo <= w_next_quo;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= DONE;
            r_quotient  <= w_next_quo;
            r_remainder <= w_next_rem;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == CALC);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset, which is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a division.
REQ-005 The block SHALL have port dividend, input, N bits, unsigned, sampled only on the accepting edge.
REQ-006 The block SHALL have port divisor, input, N bits, unsigned, sampled only on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit, high while iterating.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle result-valid pulse.
REQ-009 The block SHALL have port quotient, output, N bits, registered.
REQ-010 The block SHALL have port remainder, output, N bits, registered.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit, registered; valid together with done.

Function
REQ-012 The block SHALL be an FSM with states IDLE, CALC and DONE, plus an iteration counter of ceil(log2(N+1)) bits.
REQ-013 The block SHALL accept start only when busy=0 (IDLE or DONE); start while busy=1 SHALL be ignored and SHALL not disturb the operation in flight.
REQ-014 On an accepting edge with divisor!=0, the block SHALL latch the operands, clear the partial remainder, load the quotient shift register with dividend, set the counter to N, and enter CALC.
REQ-015 Each CALC edge SHALL shift {rem,quo} left by one and form trial = {1'b0,shifted_rem} - {1'b0,divisor}, N+1 bits wide.
REQ-016 If trial MSB=0, the block SHALL set rem=trial[N-1:0] and quo LSB=1; otherwise it SHALL keep the shifted rem and set quo LSB=0. The counter SHALL then decrement.
REQ-017 After exactly N CALC edges, the block SHALL enter DONE: done=1 for exactly one cycle, and quotient/remainder SHALL be updated with the final values.
REQ-018 Latency: with start accepted at edge t, done SHALL be high during the cycle following edge t+N.
REQ-019 From DONE, the next edge SHALL go to IDLE, or to CALC if start=1 (back-to-back, no idle cycle required).
REQ-020 If divisor=0 at the accepting edge, the block SHALL go directly to DONE (latency 1): quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-021 div_by_zero SHALL be cleared on every accepting edge with divisor!=0.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values from the done pulse until the next result is written; they SHALL not show intermediate CALC values.
REQ-023 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE.

Reset
REQ-024 rst=1 SHALL, asynchronously and at any time including mid-CALC, force the state to IDLE and clear busy, done, quotient, remainder, div_by_zero, counter and internal registers to 0.
REQ-025 After rst is released, the first accepted start SHALL behave identically to one issued after a normal completion.

Structure
REQ-026 A shared package divider_pkg SHALL hold the FSM state typedef (IDLE/CALC/DONE).
REQ-027 The trial subtraction SHALL use one instance of the existing full_substractor_n_bits at width N+1; no other sub-module.

Verification (N=4)
REQ-028 Directed test: dividend=13, divisor=3, start pulse -> busy high for 4 cycles, then done=1 with quotient=4, remainder=1, div_by_zero=0.
REQ-029 Directed test: 15/1 -> quotient=15, remainder=0; 5/7 -> quotient=0, remainder=5.
REQ-030 Directed test: 9/0 -> done 1 cycle after start, quotient=15, remainder=9, div_by_zero=1; a following 8/2 -> quotient=4, remainder=0, div_by_zero=0.
REQ-031 Directed test: 13/3 started, then start with 6/2 on CALC cycle 2 -> ignored; result 4,1 at the expected cycle.
REQ-032 Directed test: start asserted in the DONE cycle with 14/4 -> done 4 cycles later with quotient=3, remainder=2.
REQ-033 Directed test: rst pulsed mid-CALC -> all outputs 0 immediately, no done pulse, state IDLE; the next 7/2 -> quotient=3, remainder=1.
